decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports `clock` and `reset`.
REQ-002 Ports (name  direction  width  meaning), listed in REQ-002..REQ-007: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 in_valid  in  1  IF/ID holds a valid instruction; instr  in  32  instruction word; pc_plus4  in  32  PC+4 of instr.
REQ-004 rs_data  in  32  register-file port-a read data; rt_data  in  32  register-file port-b read data; rs_addr  out  5  = instr[25:21]; rt_addr  out  5  = instr[20:16] (both combinational).
REQ-005 wb_en  in  1, wb_addr  in  5, wb_data  in  32: the write port presented to the register file this cycle.
REQ-006 flush  in  1  taken branch resolved in EX, discard the ID instruction; stall  out  1  hold the PC and IF/ID this cycle (combinational).
REQ-007 ID/EX outputs, all registered:
- ex_valid 1
- ex_pc_plus4 32
- ex_rs_val 32
- ex_rt_val 32
- ex_imm 32 (sign-extended instr[15:0])
- ex_rs 5
- ex_rt 5
- ex_dest 5
- ex_alu_op 3
- ex_alu_src 1 (1 = immediate)
- ex_mem_read 1
- ex_mem_write 1
- ex_reg_write 1
- ex_branch 1

Function
REQ-008 Opcodes decoded:
- 0x00 R-type
- 0x23 lw
- 0x2B sw
- 0x04 beq
- 0x08 addi
- Any other opcode is a bubble.
REQ-009 R-type funct mapping to ex_alu_op:
- 0x20 add -> 000
- 0x22 sub -> 001
- 0x24 and -> 010
- 0x25 or -> 011
- 0x2A slt -> 100
- Any other funct is a bubble.
REQ-010 Opcode mapping:
- lw, sw, addi: alu_op 000, alu_src 1.
- beq: alu_op 001, alu_src 0, branch 1.
- lw: mem_read 1. sw: mem_write 1.
REQ-011 Destination and write enable:
- dest = instr[15:11] for R-type, instr[20:16] for lw/addi, 0 otherwise.
- reg_write = 1 for R-type/lw/addi, forced to 0 when dest = 0.
REQ-012 Operand value for each source (rs, rt):
- 0 if the address is 0.
- Else wb_data if wb_en=1 and wb_addr equals the address (write-through bypass).
- Else rs_data/rt_data.
REQ-013 Bubble definition: ex_valid=0 and all ex_ control bits (alu_op, alu_src, mem_read, mem_write, reg_write, branch, dest) = 0; data fields are don't-care.
REQ-014 Load-use hazard, evaluated combinationally; true when all of:
- ex_valid=1, ex_mem_read=1, ex_rt≠0, in_valid=1;
- instr[25:21]=ex_rt, OR (instr[20:16]=ex_rt AND opcode ∈ {R-type, sw, beq}).
REQ-015 stall = hazard AND NOT flush AND NOT reset.
REQ-016 On each rising edge, ID/EX is loaded with the first matching case:
- reset → zeros;
- flush → bubble;
- hazard → bubble;
- in_valid=0 or undecodable instr → bubble;
- otherwise → decoded instruction with ex_valid=1.
REQ-017 Latency: an instruction presented with stall=0 appears on the ex_ outputs exactly one cycle later.
REQ-018 While stall=1 the ID instruction is re-presented unchanged next cycle. Since ex_ then holds a bubble, the hazard clears and the instruction issues: load-use costs exactly one bubble.
REQ-019 flush and hazard in the same cycle: flush wins, stall=0, a bubble is inserted.
REQ-020 ex_imm = {16{instr[15]}, instr[15:0]} for all decoded types.

Reset
REQ-021 With reset=1 at a rising edge, every ex_ output SHALL become 0 on that edge; stall SHALL be 0 while reset=1.
REQ-022 A reset asserted mid-stall discards the pending hazard; the first instruction after reset deassertion issues without stall.

Verification
REQ-023 Reset, then `add $3,$1,$2` (0x00221820) with rs_data=5, rt_data=7 → next cycle: ex_valid=1, ex_rs_val=5, ex_rt_val=7, ex_dest=3, ex_alu_op=000, ex_reg_write=1.
REQ-024 `lw $4,8($1)` followed by `add $5,$4,$2` → stall=1 for one cycle, one bubble in ID/EX, then add issues with ex_rs=4.
REQ-025 ID `add $6,$7,$0` with wb_en=1, wb_addr=7, wb_data=0xDEADBEEF, rs_data=0x11 → ex_rs_val=0xDEADBEEF, ex_rt_val=0.
REQ-026 lw-use hazard with flush=1 in the same cycle → stall=0, next ex_valid=0.
REQ-027 Edge cases:
- Opcode 0x3F → bubble.
- `addi $0,$1,-1` → ex_reg_write=0, ex_imm=0xFFFFFFFF.
- `sw $4,0($1)` after `lw $4` → stall=1.

Source files
------------

// File: rtl/decode_stage_if.sv
// IF/ID-to-ID/EX bundle for the decode stage: fetch-side inputs, register-file
// ports, write-back bypass, flush/stall control and the registered ID/EX fields.
interface decode_stage_if;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc_plus4;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic [2:0]  ex_alu_op;
    logic        ex_alu_src;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_branch;

    // Handshake: there is no ready/valid back-pressure on ID/EX; the only
    // flow control is stall, which asks the fetch side to hold PC and IF/ID
    // so that the same instruction is presented again on the next cycle.
    modport master (
        output in_valid, instr, pc_plus4, rs_data, rt_data,
        output wb_en, wb_addr, wb_data, flush,
        input  rs_addr, rt_addr, stall,
        input  ex_valid, ex_pc_plus4, ex_rs_val, ex_rt_val, ex_imm,
        input  ex_rs, ex_rt, ex_dest, ex_alu_op, ex_alu_src,
        input  ex_mem_read, ex_mem_write, ex_reg_write, ex_branch
    );

    modport slave (
        input  in_valid, instr, pc_plus4, rs_data, rt_data,
        input  wb_en, wb_addr, wb_data, flush,
        output rs_addr, rt_addr, stall,
        output ex_valid, ex_pc_plus4, ex_rs_val, ex_rt_val, ex_imm,
        output ex_rs, ex_rt, ex_dest, ex_alu_op, ex_alu_src,
        output ex_mem_read, ex_mem_write, ex_reg_write, ex_branch
    );
endinterface

// File: rtl/decode_stage.sv
// Five-stage MIPS-subset decode stage: control decode, write-through operand
// bypass, load-use hazard detection and the ID/EX pipeline register.
module decode_stage (
    input  logic          clock,
    input  logic          reset,
    decode_stage_if.slave bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_plus4;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
    } idex_t;

    idex_t idex_q, idex_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_a, rt_a, rd_a;
    logic        decodable;
    logic [2:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, branch;
    logic [4:0]  dest;
    logic        hazard;
    logic        rt_is_source;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];
    assign rs_a   = bus.instr[25:21];
    assign rt_a   = bus.instr[20:16];
    assign rd_a   = bus.instr[15:11];

    always_comb begin
        decodable = 1'b0;
        alu_op    = 3'd0;
        alu_src   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        branch    = 1'b0;
        dest      = 5'd0;
        unique case (opcode)
            OP_RTYPE: begin
                decodable = 1'b1;
                dest      = rd_a;
                reg_write = 1'b1;
                case (funct)
                    6'h20:   alu_op = 3'd0;
                    6'h22:   alu_op = 3'd1;
                    6'h24:   alu_op = 3'd2;
                    6'h25:   alu_op = 3'd3;
                    6'h2A:   alu_op = 3'd4;
                    default: begin
                        decodable = 1'b0;
                        dest      = 5'd0;
                        reg_write = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                decodable = 1'b1;
                alu_src   = 1'b1;
                mem_read  = 1'b1;
                dest      = rt_a;
                reg_write = 1'b1;
            end
            OP_SW: begin
                decodable = 1'b1;
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                decodable = 1'b1;
                alu_op    = 3'd1;
                branch    = 1'b1;
            end
            OP_ADDI: begin
                decodable = 1'b1;
                alu_src   = 1'b1;
                dest      = rt_a;
                reg_write = 1'b1;
            end
            default: decodable = 1'b0;
        endcase
        // Writes to $0 are architecturally discarded, so never request one.
        if (dest == 5'd0) reg_write = 1'b0;
    end

    // The register file is read before this cycle's write lands, so a
    // matching write-back is forwarded here; $0 always reads as zero.
    function automatic logic [31:0] operand(
        input logic [4:0]  addr,
        input logic [31:0] rf_data,
        input logic        wb_en,
        input logic [4:0]  wb_addr,
        input logic [31:0] wb_data
    );
        if (addr == 5'd0)                    return 32'd0;
        else if (wb_en && (wb_addr == addr)) return wb_data;
        else                                 return rf_data;
    endfunction

    assign rt_is_source = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

    always_comb begin
        hazard = idex_q.valid && idex_q.mem_read && (idex_q.rt != 5'd0) && bus.in_valid &&
                 ((rs_a == idex_q.rt) || ((rt_a == idex_q.rt) && rt_is_source));
    end

    always_comb begin
        idex_d = '0;
        if (!bus.flush && !hazard && bus.in_valid && decodable) begin
            idex_d.valid     = 1'b1;
            idex_d.pc_plus4  = bus.pc_plus4;
            idex_d.rs_val    = operand(rs_a, bus.rs_data, bus.wb_en, bus.wb_addr, bus.wb_data);
            idex_d.rt_val    = operand(rt_a, bus.rt_data, bus.wb_en, bus.wb_addr, bus.wb_data);
            idex_d.imm       = {{16{bus.instr[15]}}, bus.instr[15:0]};
            idex_d.rs        = rs_a;
            idex_d.rt        = rt_a;
            idex_d.dest      = dest;
            idex_d.alu_op    = alu_op;
            idex_d.alu_src   = alu_src;
            idex_d.mem_read  = mem_read;
            idex_d.mem_write = mem_write;
            idex_d.reg_write = reg_write;
            idex_d.branch    = branch;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign bus.rs_addr      = rs_a;
    assign bus.rt_addr      = rt_a;
    assign bus.stall        = hazard && !bus.flush && !reset;

    assign bus.ex_valid     = idex_q.valid;
    assign bus.ex_pc_plus4  = idex_q.pc_plus4;
    assign bus.ex_rs_val    = idex_q.rs_val;
    assign bus.ex_rt_val    = idex_q.rt_val;
    assign bus.ex_imm       = idex_q.imm;
    assign bus.ex_rs        = idex_q.rs;
    assign bus.ex_rt        = idex_q.rt;
    assign bus.ex_dest      = idex_q.dest;
    assign bus.ex_alu_op    = idex_q.alu_op;
    assign bus.ex_alu_src   = idex_q.alu_src;
    assign bus.ex_mem_read  = idex_q.mem_read;
    assign bus.ex_mem_write = idex_q.mem_write;
    assign bus.ex_reg_write = idex_q.reg_write;
    assign bus.ex_branch    = idex_q.branch;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a sequential vector table with hand-computed
// results, then hand-written load-use / flush / reset-mid-stall sequences.
module tb_decode_stage;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    decode_stage_if bus ();

    decode_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic        in_valid;
        logic [31:0] pc;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        flush;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_rs_val;
        logic [31:0] e_rt_val;
        logic [31:0] e_imm;
        logic [4:0]  e_rs;
        logic [4:0]  e_rt;
        logic [4:0]  e_dest;
        logic [2:0]  e_op;
        logic [4:0]  e_ctl;  // {alu_src, mem_read, mem_write, reg_write, branch}
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs_d, input logic [31:0] rt_d,
                         input logic flush);
        bus.in_valid = 1'b1;
        bus.instr    = instr;
        bus.pc_plus4 = 32'h200;
        bus.rs_data  = rs_d;
        bus.rt_data  = rt_d;
        bus.wb_en    = 1'b0;
        bus.wb_addr  = 5'd0;
        bus.wb_data  = 32'd0;
        bus.flush    = flush;
    endtask

    function automatic logic [31:0] ctl_bits();
        return 32'({bus.ex_alu_src, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_branch});
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        bus.in_valid = 1'b0;
        bus.instr    = 32'd0;
        bus.pc_plus4 = 32'd0;
        bus.rs_data  = 32'd0;
        bus.rt_data  = 32'd0;
        bus.wb_en    = 1'b0;
        bus.wb_addr  = 5'd0;
        bus.wb_data  = 32'd0;
        bus.flush    = 1'b0;

        // instr, v, pc, rs_d, rt_d, wb_en, wb_addr, wb_data, flush |
        // stall, valid, rs_val, rt_val, imm, rs, rt, dest, alu_op, ctl
        vecs[0]  = '{32'h00221820, 1'b1, 32'h104, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b1, 32'd5, 32'd7, 32'h00001820, 5'd1, 5'd2, 5'd3, 3'd0, 5'b00010};
        vecs[1]  = '{32'h00644022, 1'b1, 32'h108, 32'd20, 32'd3, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b1, 32'd20, 32'd3, 32'h00004022, 5'd3, 5'd4, 5'd8, 3'd1, 5'b00010};
        vecs[2]  = '{32'h00224824, 1'b1, 32'h10C, 32'hF0, 32'h0F, 1'b1, 5'd2, 32'hAAAA, 1'b0,
                     1'b0, 1'b1, 32'hF0, 32'hAAAA, 32'h00004824, 5'd1, 5'd2, 5'd9, 3'd2, 5'b00010};
        vecs[3]  = '{32'h00225025, 1'b1, 32'h110, 32'h1, 32'h2, 1'b0, 5'd1, 32'h999, 1'b0,
                     1'b0, 1'b1, 32'h1, 32'h2, 32'h00005025, 5'd1, 5'd2, 5'd10, 3'd3, 5'b00010};
        vecs[4]  = '{32'h00A6582A, 1'b1, 32'h114, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'h0000582A, 5'd5, 5'd6, 5'd11, 3'd4, 5'b00010};
        vecs[5]  = '{32'h00221821, 1'b1, 32'h118, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd0, 3'd0, 5'b00000};
        vecs[6]  = '{32'hFC000000, 1'b1, 32'h11C, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 5'b00000};
        vecs[7]  = '{32'h2020FFFF, 1'b1, 32'h120, 32'd3, 32'd99, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b1, 32'd3, 32'd0, 32'hFFFFFFFF, 5'd1, 5'd0, 5'd0, 3'd0, 5'b10000};
        vecs[8]  = '{32'h20470005, 1'b1, 32'h124, 32'd8, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b1, 32'd8, 32'h77, 32'd5, 5'd2, 5'd7, 5'd7, 3'd0, 5'b10010};
        vecs[9]  = '{32'h1022FFFC, 1'b1, 32'h128, 32'd4, 32'd4, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b1, 32'd4, 32'd4, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 3'd1, 5'b00001};
        vecs[10] = '{32'h00221820, 1'b0, 32'h12C, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd0, 3'd0, 5'b00000};
        vecs[11] = '{32'h00E03020, 1'b1, 32'h130, 32'h11, 32'h55, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0,
                     1'b0, 1'b1, 32'hDEADBEEF, 32'd0, 32'h00003020, 5'd7, 5'd0, 5'd6, 3'd0, 5'b00010};
        vecs[12] = '{32'hAC240000, 1'b1, 32'h134, 32'h10, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b1, 32'h10, 32'h44, 32'd0, 5'd1, 5'd4, 5'd0, 3'd0, 5'b10100};
        vecs[13] = '{32'h8C240008, 1'b1, 32'h138, 32'h20, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b1, 32'h20, 32'd0, 32'd8, 5'd1, 5'd4, 5'd4, 3'd0, 5'b11010};
        vecs[14] = '{32'h00822820, 1'b1, 32'h13C, 32'd7, 32'd9, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 5'd4, 5'd2, 5'd0, 3'd0, 5'b00000};
        vecs[15] = '{32'h00822820, 1'b1, 32'h13C, 32'd7, 32'd9, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b1, 32'd7, 32'd9, 32'h00002820, 5'd4, 5'd2, 5'd5, 3'd0, 5'b00010};
        vecs[16] = '{32'h8C200004, 1'b1, 32'h140, 32'h30, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b1, 32'h30, 32'd0, 32'd4, 5'd1, 5'd0, 5'd0, 3'd0, 5'b11000};
        vecs[17] = '{32'h00022820, 1'b1, 32'h144, 32'h12, 32'h34, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 1'b1, 32'd0, 32'h34, 32'h00002820, 5'd0, 5'd2, 5'd5, 3'd0, 5'b00010};
        vecs[18] = '{32'h00221820, 1'b1, 32'h148, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0, 1'b1,
                     1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd0, 3'd0, 5'b00000};

        // Reset state; present a lw so the stall gate on reset is exercised.
        bus.instr    = 32'h8C240008;
        bus.in_valid = 1'b1;
        tick();
        tick();
        chk("reset_stall", 32'(bus.stall), 32'd0);
        chk("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("reset_ex_pc", bus.ex_pc_plus4, 32'd0);
        chk("reset_ex_rs_val", bus.ex_rs_val, 32'd0);
        chk("reset_ex_rt_val", bus.ex_rt_val, 32'd0);
        chk("reset_ex_imm", bus.ex_imm, 32'd0);
        chk("reset_ex_regs", 32'({bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_alu_op}), 32'd0);
        chk("reset_ex_ctl", ctl_bits(), 32'd0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 19; i++) begin
            bus.instr    = vecs[i].instr;
            bus.in_valid = vecs[i].in_valid;
            bus.pc_plus4 = vecs[i].pc;
            bus.rs_data  = vecs[i].rs_d;
            bus.rt_data  = vecs[i].rt_d;
            bus.wb_en    = vecs[i].wb_en;
            bus.wb_addr  = vecs[i].wb_addr;
            bus.wb_data  = vecs[i].wb_data;
            bus.flush    = vecs[i].flush;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_rs_addr", i), 32'(bus.rs_addr), 32'(vecs[i].e_rs));
            chk($sformatf("v%0d_rt_addr", i), 32'(bus.rt_addr), 32'(vecs[i].e_rt));
            tick();
            chk($sformatf("v%0d_ex_valid", i), 32'(bus.ex_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_ex_dest", i), 32'(bus.ex_dest), 32'(vecs[i].e_dest));
            chk($sformatf("v%0d_ex_alu_op", i), 32'(bus.ex_alu_op), 32'(vecs[i].e_op));
            chk($sformatf("v%0d_ex_ctl", i), ctl_bits(), 32'(vecs[i].e_ctl));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_ex_pc", i), bus.ex_pc_plus4, vecs[i].pc);
                chk($sformatf("v%0d_ex_rs_val", i), bus.ex_rs_val, vecs[i].e_rs_val);
                chk($sformatf("v%0d_ex_rt_val", i), bus.ex_rt_val, vecs[i].e_rt_val);
                chk($sformatf("v%0d_ex_imm", i), bus.ex_imm, vecs[i].e_imm);
                chk($sformatf("v%0d_ex_rs", i), 32'(bus.ex_rs), 32'(vecs[i].e_rs));
                chk($sformatf("v%0d_ex_rt", i), 32'(bus.ex_rt), 32'(vecs[i].e_rt));
            end
        end

        // sw $4,0($1) right after lw $4: one stall, one bubble, then issue.
        drive(32'h8C240008, 32'h20, 32'd0, 1'b0);
        tick();
        drive(32'hAC240000, 32'h10, 32'h44, 1'b0);
        #1;
        chk("sw_use_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("sw_use_bubble", 32'(bus.ex_valid), 32'd0);
        chk("sw_use_bubble_mr", 32'(bus.ex_mem_read), 32'd0);
        chk("sw_use_stall_clears", 32'(bus.stall), 32'd0);
        tick();
        chk("sw_issue_valid", 32'(bus.ex_valid), 32'd1);
        chk("sw_issue_mw", 32'(bus.ex_mem_write), 32'd1);
        chk("sw_issue_rt", 32'(bus.ex_rt), 32'd4);

        // addi reads only rs, so a matching rt is not a load-use hazard.
        drive(32'h8C240008, 32'h20, 32'd0, 1'b0);
        tick();
        drive(32'h20240001, 32'h1, 32'd0, 1'b0);
        #1;
        chk("addi_rt_no_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("addi_issue_dest", 32'(bus.ex_dest), 32'd4);

        // lw $5,0($4) after lw $4 hazards through rs; flush in that cycle wins.
        drive(32'h8C240008, 32'h20, 32'd0, 1'b0);
        tick();
        drive(32'h8C850000, 32'h20, 32'd0, 1'b0);
        #1;
        chk("lw_rs_hazard_stall", 32'(bus.stall), 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("flush_hazard_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("flush_hazard_bubble", 32'(bus.ex_valid), 32'd0);
        chk("flush_hazard_ctl", ctl_bits(), 32'd0);

        // Reset asserted mid-stall clears the hazard; add then issues unstalled.
        drive(32'h8C240008, 32'h20, 32'd0, 1'b0);
        tick();
        drive(32'h00822820, 32'd7, 32'd9, 1'b0);
        #1;
        chk("mid_stall_stall", 32'(bus.stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_stall_reset_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("mid_stall_reset_valid", 32'(bus.ex_valid), 32'd0);
        chk("mid_stall_reset_pc", bus.ex_pc_plus4, 32'd0);
        chk("mid_stall_reset_ctl", ctl_bits(), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("post_reset_valid", 32'(bus.ex_valid), 32'd1);
        chk("post_reset_rs", 32'(bus.ex_rs), 32'd4);
        chk("post_reset_dest", 32'(bus.ex_dest), 32'd5);
        chk("post_reset_rs_val", bus.ex_rs_val, 32'd7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
